despacho_alu: RTL and testbench
===============================

# despacho_alu

Issue and writeback unit that drives the ALU. It accepts 16-bit instruction words over a valid/ready handshake and reads two source registers from an internal 16×16 register file. It presents `codop`/`operando1`/`operando2` to the ALU, samples `resultado` and writes it back to the destination register. It is the producer and consumer on the opposite side of the ALU operand/result interface and sits between instruction fetch and the ALU.

## Interface
Parameters:
- `NUM_REGS`, 16: register-file depth; fixed 16, since the index fields are 4 bits.
- `LARGURA`, 16: data width; must match the ALU operand width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr`  in  16  instruction word: [15:12] codop, [11:8] rd, [7:4] rs1, [3:0] rs2.
- `instr_valido`  in  1  `instr` is valid.
- `instr_pronto`  out  1  unit can accept an instruction.
- `codop`  out  4  opcode to the ALU.
- `operando1`  out  16  first ALU operand, R[rs1].
- `operando2`  out  16  second ALU operand, R[rs2].
- `resultado`  in  16  ALU result.
- `concluido`  out  1  one-cycle pulse at writeback.
- `rd_escrito`  out  4  destination index, valid with `concluido`.
- `valor_escrito`  out  16  value written, valid with `concluido`.
- `erro`  out  1  one-cycle pulse on an unsupported codop.

## Operation
- FSM states: OCIOSO, LEITURA, EXECUTA, ESCRITA.
- OCIOSO:
  - `instr_pronto`=1.
  - On `instr_valido && instr_pronto`, latch `instr` and go to LEITURA.
  - Otherwise stay.
- LEITURA:
  - Register R[rs1] into `operando1`, R[rs2] into `operando2`, and codop into `codop`.
  - Next state: EXECUTA.
- EXECUTA:
  - Operands held stable; the ALU registers its result at the end of this cycle.
  - Next state: ESCRITA.
- ESCRITA:
  - Sample `resultado`.
  - For codop 0/1/2: write R[rd], pulse `concluido`, drive `rd_escrito`/`valor_escrito`.
  - Any other codop: no write, no `concluido`, pulse `erro`.
  - Next state: OCIOSO.
- Supported ALU codops: 0 add, 1 sub, 2 unsigned greater-than (result 1/0).
- Register 0:
  - Always reads 0.
  - A write to rd=0 is discarded, but `concluido` still pulses with `valor_escrito` = ALU result.
- Width rules: all arithmetic is in the ALU, modulo 2^16; this unit performs no extension or truncation.
- Hazards: none, because instructions are strictly serialized. A source equal to the previous rd reads the already-written value.
- `instr_valido` while not in OCIOSO is ignored. The producer must hold the word until accepted.

## Timing
- Accept at edge N; operands visible on outputs after edge N+1; writeback at edge N+3.
- `concluido` is high during cycle N+3 → N+4.
- Throughput: one instruction per 4 cycles. `instr_pronto` returns high the cycle after ESCRITA.
- Reset values:
  - State OCIOSO.
  - `instr_pronto`=0 during reset, 1 the first cycle after.
  - `codop`=0, `operando1`=0, `operando2`=0.
  - `concluido`=0, `erro`=0, `rd_escrito`=0, `valor_escrito`=0.
  - All registers = 0.
- Reset mid-instruction: the instruction is abandoned with no writeback and no pulse. Reset has priority over every transition.
- `concluido` and `erro` are mutually exclusive.

## Configuration
- `DESPACHO_LDI_EN` defined:
  - codop 4'hF is load-immediate: R[rd] ← {8'h00, instr[7:0]}.
  - The ALU is bypassed; `codop` is still driven with F.
  - Completes in ESCRITA with the same 4-cycle timing and pulses `concluido`.
- `DESPACHO_LDI_EN` undefined: codop F is unsupported and pulses `erro`.

## Structure
- Shared package `despacho_pkg`:
  - Codop constants: OP_SOMA=0, OP_SUB=1, OP_MAIOR=2, OP_LDI=F.
  - FSM state enum.
  - Instruction field bit positions.
- One sub-module, `banco_registradores`: 16×16, two combinational read ports, one synchronous write port, register 0 forced to zero, synchronous reset clears all entries.

## Test plan
- Reset, then check all outputs → `instr_pronto`=1, all others 0, R1..R15 read 0.
- `DESPACHO_LDI_EN` defined: LDI R1=0x05, LDI R2=0x03, then add R3=R1+R2 → `concluido` with rd=3, value 0x0008, exactly 3 cycles after accept.
- Sub R4=R2−R1 (3−5) → value 0xFFFE. Greater-than R5=(R1>R2) → 0x0001. Greater-than R6=(R2>R1) → 0x0000.
- Codop 4'h7 with rd=7 → `erro` pulse only; R7 unchanged at 0; `instr_pronto` back after 4 cycles.
- Add R0=R1+R1 → `concluido` with value 0x000A; a subsequent read of R0 gives 0.
- Assert `reset` in EXECUTA of add R8=R1+R2 → no `concluido`, R8=0, `instr_pronto`=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/despacho_pkg.sv
// despacho_pkg: shared constants, FSM state type and instruction field
// positions for the despacho_alu issue/writeback unit.
// Optional feature: DESPACHO_LDI_EN enables the load-immediate codop (4'hF).
package despacho_pkg;

  // ALU operation codes understood by this unit
  localparam logic [3:0] OP_SOMA  = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_MAIOR = 4'h2;
  localparam logic [3:0] OP_LDI   = 4'hF;

  // Instruction word layout: [15:12] codop, [11:8] rd, [7:4] rs1, [3:0] rs2
  localparam int CODOP_MSB = 15;
  localparam int CODOP_LSB = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 8;
  localparam int RS1_MSB   = 7;
  localparam int RS1_LSB   = 4;
  localparam int RS2_MSB   = 3;
  localparam int RS2_LSB   = 0;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LEITURA = 2'd1,
    EXECUTA = 2'd2,
    ESCRITA = 2'd3
  } estado_t;

  // True when the codop completes with a writeback rather than an error
  function automatic logic codop_suportado(input logic [3:0] op);
    logic ok;
    ok = (op == OP_SOMA) || (op == OP_SUB) || (op == OP_MAIOR);
`ifdef DESPACHO_LDI_EN
    ok = ok || (op == OP_LDI);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/banco_registradores.sv
// banco_registradores: register file with two combinational read ports and
// one synchronous write port. Entry 0 is hard-wired to zero; synchronous
// reset clears every entry.
module banco_registradores #(
  parameter int NUM_REGS = 16,
  parameter int LARGURA  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        escrita_en,
  input  logic [$clog2(NUM_REGS)-1:0] end_escrita,
  input  logic [LARGURA-1:0]          dado_escrita,
  input  logic [$clog2(NUM_REGS)-1:0] end_leitura1,
  input  logic [$clog2(NUM_REGS)-1:0] end_leitura2,
  output logic [LARGURA-1:0]          dado_leitura1,
  output logic [LARGURA-1:0]          dado_leitura2
);

  localparam int AW = $clog2(NUM_REGS);

  logic [LARGURA-1:0] regs_q [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [LARGURA-1:0] reg_q;
      logic [LARGURA-1:0] reg_d;

      if (gi == 0) begin : g_zero
        // Entry 0 never changes: writes to it are discarded
        always_comb reg_d = '0;
      end else begin : g_rw
        // Capture the write data when this entry is addressed
        always_comb begin
          reg_d = reg_q;
          if (escrita_en && (end_escrita == AW'(gi))) begin
            reg_d = dado_escrita;
          end
        end
      end

      // Storage flop for one entry, cleared by reset
      always_ff @(posedge clk) begin
        if (reset) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_q[gi] = reg_q;
    end
  endgenerate

  // Read ports are combinational; index 0 yields zero regardless of storage
  always_comb begin
    dado_leitura1 = (end_leitura1 == '0) ? '0 : regs_q[end_leitura1];
    dado_leitura2 = (end_leitura2 == '0) ? '0 : regs_q[end_leitura2];
  end

endmodule

// File: rtl/despacho_alu.sv
// despacho_alu: issue and writeback unit for an external ALU. Accepts one
// instruction per four cycles, reads R[rs1]/R[rs2], presents them to the ALU
// and writes the sampled result back to R[rd].
// Optional feature: DESPACHO_LDI_EN makes codop 4'hF load {8'h00, instr[7:0]}.
module despacho_alu
  import despacho_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int LARGURA  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        instr,
  input  logic               instr_valido,
  output logic               instr_pronto,
  output logic [3:0]         codop,
  output logic [LARGURA-1:0] operando1,
  output logic [LARGURA-1:0] operando2,
  input  logic [LARGURA-1:0] resultado,
  output logic               concluido,
  output logic [3:0]         rd_escrito,
  output logic [LARGURA-1:0] valor_escrito,
  output logic               erro
);

  estado_t            estado_q, estado_d;
  logic [15:0]        instr_q, instr_d;
  logic               instr_pronto_q, instr_pronto_d;
  logic [3:0]         codop_q, codop_d;
  logic [LARGURA-1:0] operando1_q, operando1_d;
  logic [LARGURA-1:0] operando2_q, operando2_d;
  logic               concluido_q, concluido_d;
  logic               erro_q, erro_d;
  logic [3:0]         rd_escrito_q, rd_escrito_d;
  logic [LARGURA-1:0] valor_escrito_q, valor_escrito_d;

  logic [3:0]         campo_codop, campo_rd, campo_rs1, campo_rs2;
  logic [LARGURA-1:0] dado_rs1, dado_rs2;
  logic [LARGURA-1:0] valor_wb;
  logic               escrita_en;

  assign campo_codop = instr_q[CODOP_MSB:CODOP_LSB];
  assign campo_rd    = instr_q[RD_MSB:RD_LSB];
  assign campo_rs1   = instr_q[RS1_MSB:RS1_LSB];
  assign campo_rs2   = instr_q[RS2_MSB:RS2_LSB];

  banco_registradores #(
    .NUM_REGS (NUM_REGS),
    .LARGURA  (LARGURA)
  ) u_banco (
    .clk           (clk),
    .reset         (reset),
    .escrita_en    (escrita_en),
    .end_escrita   (campo_rd),
    .dado_escrita  (valor_wb),
    .end_leitura1  (campo_rs1),
    .end_leitura2  (campo_rs2),
    .dado_leitura1 (dado_rs1),
    .dado_leitura2 (dado_rs2)
  );

  // Writeback value: the ALU result, or the zero-extended immediate for LDI
`ifdef DESPACHO_LDI_EN
  always_comb begin
    valor_wb = resultado;
    if (campo_codop == OP_LDI) begin
      valor_wb = {{(LARGURA-8){1'b0}}, instr_q[IMM_MSB:IMM_LSB]};
    end
  end
`else
  always_comb valor_wb = resultado;
`endif

  // Next-state and next-output logic for the four-phase issue sequence
  always_comb begin
    estado_d        = estado_q;
    instr_d         = instr_q;
    codop_d         = codop_q;
    operando1_d     = operando1_q;
    operando2_d     = operando2_q;
    concluido_d     = 1'b0;
    erro_d          = 1'b0;
    rd_escrito_d    = rd_escrito_q;
    valor_escrito_d = valor_escrito_q;
    escrita_en      = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (instr_valido && instr_pronto_q) begin
          instr_d  = instr;
          estado_d = LEITURA;
        end
      end
      LEITURA: begin
        codop_d     = campo_codop;
        operando1_d = dado_rs1;
        operando2_d = dado_rs2;
        estado_d    = EXECUTA;
      end
      EXECUTA: begin
        estado_d = ESCRITA;
      end
      ESCRITA: begin
        if (codop_suportado(campo_codop)) begin
          // rd=0 still reports completion; the register file drops the write
          escrita_en      = 1'b1;
          concluido_d     = 1'b1;
          rd_escrito_d    = campo_rd;
          valor_escrito_d = valor_wb;
        end else begin
          erro_d = 1'b1;
        end
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    // Ready is registered so it stays low during reset and rises one cycle later
    instr_pronto_d = (estado_d == OCIOSO);
  end

  // State and registered outputs; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q        <= OCIOSO;
      instr_q         <= '0;
      instr_pronto_q  <= 1'b0;
      codop_q         <= '0;
      operando1_q     <= '0;
      operando2_q     <= '0;
      concluido_q     <= 1'b0;
      erro_q          <= 1'b0;
      rd_escrito_q    <= '0;
      valor_escrito_q <= '0;
    end else begin
      estado_q        <= estado_d;
      instr_q         <= instr_d;
      instr_pronto_q  <= instr_pronto_d;
      codop_q         <= codop_d;
      operando1_q     <= operando1_d;
      operando2_q     <= operando2_d;
      concluido_q     <= concluido_d;
      erro_q          <= erro_d;
      rd_escrito_q    <= rd_escrito_d;
      valor_escrito_q <= valor_escrito_d;
    end
  end

  assign instr_pronto  = instr_pronto_q;
  assign codop         = codop_q;
  assign operando1     = operando1_q;
  assign operando2     = operando2_q;
  assign concluido     = concluido_q;
  assign erro          = erro_q;
  assign rd_escrito    = rd_escrito_q;
  assign valor_escrito = valor_escrito_q;

endmodule

// File: tb/tb_despacho_alu.sv
// tb_despacho_alu: self-checking bench for despacho_alu. The bench plays the
// ALU (result registered one cycle after the operands) and keeps a plain
// array model of the architectural registers. The ALU stand-in can be told
// to return a chosen value, which seeds registers with arbitrary data since
// the unit writes back whatever the ALU returns.
module tb_despacho_alu;
  import despacho_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valido = 1'b0;
  logic        instr_pronto;
  logic [3:0]  codop;
  logic [15:0] operando1, operando2;
  logic [15:0] resultado = '0;
  logic        concluido;
  logic [3:0]  rd_escrito;
  logic [15:0] valor_escrito;
  logic        erro;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_r [16];
  bit          alu_force = 1'b0;
  logic [15:0] alu_force_val = '0;

  despacho_alu #(.NUM_REGS(16), .LARGURA(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .instr_valido  (instr_valido),
    .instr_pronto  (instr_pronto),
    .codop         (codop),
    .operando1     (operando1),
    .operando2     (operando2),
    .resultado     (resultado),
    .concluido     (concluido),
    .rd_escrito    (rd_escrito),
    .valor_escrito (valor_escrito),
    .erro          (erro)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return (a > b) ? 16'd1 : 16'd0;
      default: return 16'hDEAD;
    endcase
  endfunction

  // ALU stand-in: registers its result every cycle from the presented operands
  always @(posedge clk) begin
    resultado <= alu_force ? alu_force_val : alu_ref(codop, operando1, operando2);
  end

  function automatic bit is_supported(input logic [3:0] op);
`ifdef DESPACHO_LDI_EN
    return (op <= 4'h2) || (op == 4'hF);
`else
    return (op <= 4'h2);
`endif
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model_r[i] = 16'h0000;
  endtask

  // Issue one instruction and check every phase against the model
  task automatic do_instr(input logic [15:0] iw, input bit force_en,
                          input logic [15:0] force_val, output logic [15:0] got_val);
    logic [3:0]  op, rd, rs1, rs2;
    logic [15:0] e_op1, e_op2, e_val;
    bit          sup;
    int          waited;
    op = iw[15:12]; rd = iw[11:8]; rs1 = iw[7:4]; rs2 = iw[3:0];
    e_op1 = model_r[rs1];
    e_op2 = model_r[rs2];
    sup = is_supported(op);
    if (op == 4'hF) e_val = {8'h00, iw[7:0]};
    else if (force_en) e_val = force_val;
    else if (op == 4'h0) e_val = e_op1 + e_op2;
    else if (op == 4'h1) e_val = e_op1 - e_op2;
    else e_val = (e_op1 > e_op2) ? 16'd1 : 16'd0;

    @(negedge clk);
    waited = 0;
    while (instr_pronto !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (instr_pronto !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait: instr_pronto=%b required 1 within 8 cycles", instr_pronto);
    end

    alu_force = force_en;
    alu_force_val = force_val;
    instr = iw;
    instr_valido = 1'b1;
    @(negedge clk);  // LEITURA: accepted at previous edge
    n_checks++;
    if (instr_pronto !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: instr_pronto=%b required 0", instr_pronto);
    end
    // garbage offered while busy must be ignored
    instr = 16'($urandom);
    @(negedge clk);  // EXECUTA: operands visible
    n_checks++;
    if (codop !== op || operando1 !== e_op1 || operando2 !== e_op2) begin
      n_fail++;
      $display("FAIL operands: codop=%h op1=%h op2=%h required %h %h %h", codop, operando1, operando2, op, e_op1, e_op2);
    end
    @(negedge clk);  // ESCRITA: no pulse yet
    instr_valido = 1'b0;
    n_checks++;
    if (concluido !== 1'b0 || erro !== 1'b0) begin
      n_fail++;
      $display("FAIL early_pulse: concluido=%b erro=%b required 0 0", concluido, erro);
    end
    @(negedge clk);  // three edges after accept
    alu_force = 1'b0;
    got_val = valor_escrito;
    n_checks++;
    if (concluido !== sup || erro !== !sup || instr_pronto !== 1'b1) begin
      n_fail++;
      $display("FAIL writeback_pulse: concluido=%b erro=%b pronto=%b required %b %b 1", concluido, erro, instr_pronto, sup, !sup);
    end
    if (sup) begin
      n_checks++;
      if (rd_escrito !== rd || valor_escrito !== e_val) begin
        n_fail++;
        $display("FAIL writeback_data: rd=%0d val=%h required rd=%0d val=%h", rd_escrito, valor_escrito, rd, e_val);
      end
    end
    @(negedge clk);
    n_checks++;
    if (concluido !== 1'b0 || erro !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width: concluido=%b erro=%b required 0 0", concluido, erro);
    end
    if (sup && rd != 4'd0) model_r[rd] = e_val;
    $display("instr %h op=%h rd=%0d rs1=%0d rs2=%0d op1=%h op2=%h -> %s value %h",
             iw, op, rd, rs1, rs2, e_op1, e_op2, sup ? "write" : "error", e_val);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (instr_pronto !== 1'b0 || codop !== 4'h0 || operando1 !== 16'h0 || operando2 !== 16'h0 ||
        concluido !== 1'b0 || erro !== 1'b0 || rd_escrito !== 4'h0 || valor_escrito !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: pronto=%b codop=%h op1=%h op2=%h conc=%b erro=%b rd=%h val=%h required all 0",
               instr_pronto, codop, operando1, operando2, concluido, erro, rd_escrito, valor_escrito);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (instr_pronto !== 1'b1 || concluido !== 1'b0 || erro !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: pronto=%b conc=%b erro=%b required 1 0 0", instr_pronto, concluido, erro);
    end
    clear_model();
    // read every register through add R0 = Rk + R0
    for (int k = 1; k < 16; k++) begin
      do_instr({OP_SOMA, 4'd0, 4'(k), 4'd0}, 1'b0, 16'h0, v);
    end
  endtask

  task automatic test_plan_values();
    logic [15:0] v;
`ifdef DESPACHO_LDI_EN
    do_instr({OP_LDI, 4'd1, 8'h05}, 1'b0, 16'h0, v);
    do_instr({OP_LDI, 4'd2, 8'h03}, 1'b0, 16'h0, v);
`else
    do_instr({OP_SOMA, 4'd1, 4'd0, 4'd0}, 1'b1, 16'h0005, v);
    do_instr({OP_SOMA, 4'd2, 4'd0, 4'd0}, 1'b1, 16'h0003, v);
    // codop F is unsupported in this build: error only, R1 keeps 5
    do_instr({4'hF, 4'd1, 8'hAA}, 1'b0, 16'h0, v);
`endif
    do_instr({OP_SOMA, 4'd3, 4'd1, 4'd2}, 1'b0, 16'h0, v);
    n_checks++;
    if (v !== 16'h0008) begin n_fail++; $display("FAIL add_r3: got %h required 0008", v); end
    do_instr({OP_SUB, 4'd4, 4'd2, 4'd1}, 1'b0, 16'h0, v);
    n_checks++;
    if (v !== 16'hFFFE) begin n_fail++; $display("FAIL sub_r4: got %h required FFFE", v); end
    do_instr({OP_MAIOR, 4'd5, 4'd1, 4'd2}, 1'b0, 16'h0, v);
    n_checks++;
    if (v !== 16'h0001) begin n_fail++; $display("FAIL gt_r5: got %h required 0001", v); end
    do_instr({OP_MAIOR, 4'd6, 4'd2, 4'd1}, 1'b0, 16'h0, v);
    n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL gt_r6: got %h required 0000", v); end
    do_instr({4'h7, 4'd7, 4'd1, 4'd2}, 1'b0, 16'h0, v);
    do_instr({OP_SOMA, 4'd0, 4'd7, 4'd0}, 1'b0, 16'h0, v);
    n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL r7_untouched: got %h required 0000", v); end
    do_instr({OP_SOMA, 4'd0, 4'd1, 4'd1}, 1'b0, 16'h0, v);
    n_checks++;
    if (v !== 16'h000A) begin n_fail++; $display("FAIL add_r0: got %h required 000A", v); end
    // R0 still reads zero: operand check inside do_instr covers it
    do_instr({OP_SOMA, 4'd9, 4'd0, 4'd1}, 1'b0, 16'h0, v);
    n_checks++;
    if (v !== 16'h0005) begin n_fail++; $display("FAIL r0_reads_zero: got %h required 0005", v); end
  endtask

  task automatic test_reset_mid_instr();
    logic [15:0] v;
    @(negedge clk);
    instr = {OP_SOMA, 4'd8, 4'd1, 4'd2};
    instr_valido = 1'b1;
    @(negedge clk);  // LEITURA
    instr_valido = 1'b0;
    @(negedge clk);  // EXECUTA
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (concluido !== 1'b0 || erro !== 1'b0 || instr_pronto !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_abandon: conc=%b erro=%b pronto=%b required 0 0 0", concluido, erro, instr_pronto);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (instr_pronto !== 1'b1 || concluido !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: pronto=%b conc=%b required 1 0", instr_pronto, concluido);
    end
    $display("instr %h abandoned by reset in EXECUTA", {OP_SOMA, 4'd8, 4'd1, 4'd2});
    clear_model();
    do_instr({OP_SOMA, 4'd0, 4'd8, 4'd1}, 1'b0, 16'h0, v);
    n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL r8_after_reset: got %h required 0000", v); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [3:0]  op;
    for (int k = 1; k < 16; k++) begin
      do_instr({OP_SOMA, 4'(k), 4'd0, 4'd0}, 1'b1, 16'($urandom), v);
    end
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = OP_SOMA;
        3, 4:    op = OP_SUB;
        5, 6:    op = OP_MAIOR;
        default: op = 4'($urandom);
      endcase
      do_instr({op, 4'($urandom), 4'($urandom), 4'($urandom)}, 1'b0, 16'h0, v);
    end
    // back-to-back readback of all registers
    for (int k = 1; k < 16; k++) begin
      do_instr({OP_SOMA, 4'd0, 4'(k), 4'd0}, 1'b0, 16'h0, v);
      n_checks++;
      if (v !== model_r[k]) begin n_fail++; $display("FAIL readback_r%0d: got %h required %h", k, v, model_r[k]); end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_plan_values();
    test_reset_mid_instr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
